// File: rtl/i2s_pkg.sv
// Shared types for the I2S/TDM clock master: framing modes and control FSM states.
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_MODE_I2S = 2'd0,
    I2S_MODE_LJ  = 2'd1,
    I2S_MODE_DSP = 2'd2
  } i2s_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2s_sck_div.sv
// SCK divider: low half then high half per bit period, registered edge strobes; wrap_o flags the last
// clk of a bit period so the caller can advance counters in the same cycle the fall strobe appears.
module i2s_sck_div #(
  parameter int SCK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic restart_i,
  output logic sck_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic wrap_o
);

  localparam int CW = $clog2(SCK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  assign wrap_o  = (cnt_q == CW'(SCK_DIV - 1));
  assign cnt_nxt = wrap_o ? '0 : cnt_q + CW'(1);

  // Stopping forces SCK low; a pending high phase is reported as a fall so strobes stay consistent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      sck_o      <= 1'b0;
      sck_rise_o <= 1'b0;
      sck_fall_o <= 1'b0;
    end else if (restart_i || !en_i) begin
      cnt_q      <= '0;
      sck_o      <= 1'b0;
      sck_rise_o <= 1'b0;
      sck_fall_o <= sck_o;
    end else begin
      cnt_q      <= cnt_nxt;
      sck_o      <= (cnt_nxt >= CW'(SCK_DIV / 2));
      sck_rise_o <= (cnt_nxt == CW'(SCK_DIV / 2));
      sck_fall_o <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/i2s_tdm_clock_gen.sv
// I2S / left-justified / DSP-TDM bit and frame clock master with clean start and frame-aligned stop.
// Define I2S_CLKGEN_MCLK_EN to add the free-running mclk_o output.
module i2s_tdm_clock_gen
  import i2s_pkg::*;
#(
  parameter int SCK_DIV   = 8,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2,
  parameter bit WS_POL    = 1'b0,
  parameter int MCLK_DIV  = 2,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int BW = $clog2(SLOT_BITS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  output logic          sck_o,
  output logic          ws_o,
  output logic          sck_rise_o,
  output logic          sck_fall_o,
  output logic          frame_start_o,
  output logic [SW-1:0] slot_o,
  output logic [BW-1:0] bit_o,
  output logic          running_o
`ifdef I2S_CLKGEN_MCLK_EN
  ,
  output logic          mclk_o
`endif
);

  if (SCK_DIV < 2 || (SCK_DIV % 2) != 0) begin : g_bad_sck_div
    $fatal(1, "SCK_DIV must be even and >= 2");
  end
  if (SLOT_BITS < 2 || SLOT_BITS > 64) begin : g_bad_slot_bits
    $fatal(1, "SLOT_BITS must be in 2..64");
  end
  if (NUM_SLOTS < 1) begin : g_bad_num_slots
    $fatal(1, "NUM_SLOTS must be >= 1");
  end
  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
    $fatal(1, "MCLK_DIV must be even and >= 2");
  end

  i2s_state_e    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d, slot_adv;
  logic [1:0]    mode_q, mode_d;
  logic          ws_q, ws_d;
  logic          fs_q, fs_d;
  logic          restart, tick, last_bit, last_slot;

  assign last_bit  = (bit_q == BW'(SLOT_BITS - 1));
  assign last_slot = (slot_q == SW'(NUM_SLOTS - 1));

  i2s_sck_div #(.SCK_DIV(SCK_DIV)) u_sck_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (state_d != ST_IDLE),
    .restart_i  (restart),
    .sck_o      (sck_o),
    .sck_rise_o (sck_rise_o),
    .sck_fall_o (sck_fall_o),
    .wrap_o     (tick)
  );

  function automatic logic lj_level(input logic [SW-1:0] s);
    return (s < SW'(NUM_SLOTS / 2)) ? WS_POL : ~WS_POL;
  endfunction

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    mode_d  = mode_q;
    fs_d    = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
          restart = 1'b1;
          mode_d  = mode_i;
          fs_d    = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // A stop only lands where the next frame would begin, so no partial frame is ever emitted.
        if (state_q == ST_DRAIN && !en_i && tick && last_bit && last_slot) begin
          state_d = ST_IDLE;
          bit_d   = '0;
          slot_d  = '0;
        end else begin
          state_d = en_i ? ST_RUN : ST_DRAIN;
          if (tick) begin
            if (!last_bit) begin
              bit_d = bit_q + BW'(1);
            end else begin
              bit_d = '0;
              if (!last_slot) begin
                slot_d = slot_q + SW'(1);
              end else begin
                slot_d = '0;
                fs_d   = 1'b1;
                mode_d = mode_i;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bit_d   = '0;
        slot_d  = '0;
      end
    endcase
  end

  // I2S reuses the LJ level of the following bit, which shifts WS one SCK period earlier.
  always_comb begin
    slot_adv = slot_d;
    if (bit_d == BW'(SLOT_BITS - 1)) begin
      slot_adv = (slot_d == SW'(NUM_SLOTS - 1)) ? '0 : slot_d + SW'(1);
    end
    if (state_d == ST_IDLE) begin
      ws_d = (mode_d == I2S_MODE_DSP) ? 1'b0 : WS_POL;
    end else if (mode_d == I2S_MODE_LJ) begin
      ws_d = lj_level(slot_d);
    end else if (mode_d == I2S_MODE_DSP) begin
      ws_d = (slot_d == '0) && (bit_d == '0);
    end else begin
      ws_d = lj_level(slot_adv);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      mode_q  <= I2S_MODE_I2S;
      ws_q    <= WS_POL;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      mode_q  <= mode_d;
      ws_q    <= ws_d;
      fs_q    <= fs_d;
    end
  end

  assign ws_o          = ws_q;
  assign frame_start_o = fs_q;
  assign slot_o        = slot_q;
  assign bit_o         = bit_q;
  assign running_o     = (state_q != ST_IDLE);

`ifdef I2S_CLKGEN_MCLK_EN
  localparam int MW = (MCLK_DIV > 2) ? $clog2(MCLK_DIV / 2) : 1;

  logic [MW-1:0] mclk_cnt_q;
  logic          mclk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
    end else if (mclk_cnt_q == MW'(MCLK_DIV / 2 - 1)) begin
      mclk_cnt_q <= '0;
      mclk_q     <= ~mclk_q;
    end else begin
      mclk_cnt_q <= mclk_cnt_q + MW'(1);
    end
  end

  assign mclk_o = mclk_q;
`endif

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Bench for i2s_tdm_clock_gen: two instances (2x32 and 8x16 slots) against an elapsed-time reference model.
module tb_i2s_tdm_clock_gen;
  localparam bit POL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;

  logic       sck_a, ws_a, rise_a, fall_a, fs_a, run_a;
  logic [0:0] slot_a;
  logic [4:0] bit_a;
  logic       sck_b, ws_b, rise_b, fall_b, fs_b, run_b;
  logic [2:0] slot_b;
  logic [3:0] bit_b;
`ifdef I2S_CLKGEN_MCLK_EN
  logic       mclk_a, mclk_b;
`endif

  always #5 clk = ~clk;

  i2s_tdm_clock_gen #(.SCK_DIV(8), .SLOT_BITS(32), .NUM_SLOTS(2), .WS_POL(POL)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .sck_o(sck_a), .ws_o(ws_a), .sck_rise_o(rise_a), .sck_fall_o(fall_a),
    .frame_start_o(fs_a), .slot_o(slot_a), .bit_o(bit_a), .running_o(run_a)
`ifdef I2S_CLKGEN_MCLK_EN
    , .mclk_o(mclk_a)
`endif
  );

  i2s_tdm_clock_gen #(.SCK_DIV(8), .SLOT_BITS(16), .NUM_SLOTS(8), .WS_POL(POL)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .sck_o(sck_b), .ws_o(ws_b), .sck_rise_o(rise_b), .sck_fall_o(fall_b),
    .frame_start_o(fs_b), .slot_o(slot_b), .bit_o(bit_b), .running_o(run_b)
`ifdef I2S_CLKGEN_MCLK_EN
    , .mclk_o(mclk_b)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: elapsed clks since run entry, framing rules applied arithmetically.
  bit    act[2], drn[2], psck[2];
  int    t[2], md[2];
  int    exp_v[2][8];
  int    obs[8];
  string nm[8] = '{"sck", "ws", "sck_rise", "sck_fall", "frame_start", "slot", "bit", "running"};

  function automatic int p_sb(input int i);  return (i == 0) ? 32 : 16; endfunction
  function automatic int p_ns(input int i);  return (i == 0) ? 2 : 8;   endfunction
  function automatic int lj(input int bp, input int half); return (bp < half) ? int'(POL) : int'(!POL); endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; drn[i] = 0; psck[i] = 0; t[i] = 0; md[i] = 0;
      exp_v[i] = '{0, int'(POL), 0, 0, 0, 0, 0, 0};
    end
  endtask

  task automatic model_step(input int i);
    int fb, fl, sck, ws, bp;
    fb = p_sb(i) * p_ns(i);
    fl = 8 * fb;
    if (!act[i]) begin
      if (en) begin act[i] = 1; t[i] = 0; md[i] = int'(mode); drn[i] = 0; end
    end else if (drn[i] && !en && ((t[i] + 1) % fl) == 0) begin
      act[i] = 0; t[i] = 0;
    end else begin
      t[i]++;
      if (t[i] % fl == 0) md[i] = int'(mode);
      drn[i] = !en;
    end
    bp  = (t[i] / 8) % fb;
    sck = (act[i] && (t[i] % 8) >= 4) ? 1 : 0;
    if (!act[i])       ws = (md[i] == 2) ? 0 : int'(POL);
    else if (md[i] == 1) ws = lj(bp, fb / 2);
    else if (md[i] == 2) ws = (bp == 0) ? 1 : 0;
    else               ws = lj((bp + 1) % fb, fb / 2);
    exp_v[i][0] = sck;
    exp_v[i][1] = ws;
    exp_v[i][2] = (sck == 1 && !psck[i]) ? 1 : 0;
    exp_v[i][3] = (sck == 0 && psck[i]) ? 1 : 0;
    exp_v[i][4] = (act[i] && t[i] % fl == 0) ? 1 : 0;
    exp_v[i][5] = act[i] ? bp / p_sb(i) : 0;
    exp_v[i][6] = act[i] ? bp % p_sb(i) : 0;
    exp_v[i][7] = int'(act[i]);
    psck[i] = (sck == 1);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) obs = '{int'(sck_a), int'(ws_a), int'(rise_a), int'(fall_a), int'(fs_a),
                          int'(slot_a), int'(bit_a), int'(run_a)};
      else        obs = '{int'(sck_b), int'(ws_b), int'(rise_b), int'(fall_b), int'(fs_b),
                          int'(slot_b), int'(bit_b), int'(run_b)};
      for (int k = 0; k < 8; k++) check($sformatf("u%0d_%s", i, nm[k]), obs[k], exp_v[i][k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(hold);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int i, input int slot, input int bt, input string tag);
    int n = 0;
    while (!(exp_v[i][7] == 1 && exp_v[i][5] == slot && exp_v[i][6] == bt) && n < 4000) begin
      tick();
      n++;
    end
    check(tag, (n < 4000) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 2'd1;
    #2;
    do_reset(3);

    en = 1'b1; mode = 2'd1;                 // LJ, continuous
    run(1100);
    run_until(0, 0, 5, "wait_stop_point");  // stop at slot 0 bit 5, drain to frame end
    en = 1'b0;
    run(1200);

    en = 1'b1; run(1); en = 1'b0;           // one-clk pulse in IDLE: one full frame
    run(1200);

    en = 1'b1; mode = 2'd0;                 // I2S
    run(1100);
    run_until(0, 0, 5, "wait_drain");       // drain then re-enable without a gap
    en = 1'b0; run(150); en = 1'b1;
    run(600);

    mode = 2'd1; run(1100);                 // LJ -> DSP change mid-frame
    run_until(0, 0, 9, "wait_mode_chg");
    mode = 2'd2;
    run(2200);
    mode = 2'd3; run(1100);                 // reserved code behaves as I2S

    run_until(0, 1, 3, "wait_slot1");       // reset mid-slot 1, then a clean restart
    do_reset(2);
    mode = 2'd1;
    run(1100);

    for (int s = 0; s < 20; s++) begin
      en   = ($urandom % 4) != 0;
      mode = 2'($urandom % 4);
      if ($urandom % 8 == 0) do_reset(int'($urandom_range(1, 3)));
      run(int'($urandom_range(1, 600)));
    end
    en = 1'b0;
    run(2200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
